// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared types and constants for the intersection light sequencer.
//   - phase_e   : sequencer state encoding, also driven out on the phase port
//   - timer_t   : 7-bit phase countdown value
//   - N1..W2    : lane bit positions within the WWSSEENN lane vector
//   - DEF_*     : default phase lengths in clock cycles
//   - clampGreen: raises a requested green length to the minimum green
package traffic_pkg;

    typedef logic [6:0] timer_t;

    typedef enum logic [2:0] {
        PH_SELECT  = 3'd1,
        PH_GREEN   = 3'd2,
        PH_YELLOW  = 3'd3,
        PH_ALL_RED = 3'd4,
        PH_PED     = 3'd5,
        PH_EMG     = 3'd6
    } phase_e;

    localparam int N1 = 0;
    localparam int N2 = 1;
    localparam int E1 = 2;
    localparam int E2 = 3;
    localparam int S1 = 4;
    localparam int S2 = 5;
    localparam int W1 = 6;
    localparam int W2 = 7;

    localparam int DEF_YELLOW_CYCLES  = 3;
    localparam int DEF_ALL_RED_CYCLES = 2;
    localparam int DEF_PED_CYCLES     = 10;
    localparam int DEF_MIN_GREEN      = 2;

    function automatic timer_t clampGreen(input timer_t req, input timer_t minGreen);
        return (req < minGreen) ? minGreen : req;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer
//   Loadable 7-bit down counter that times each sequencer phase.
//   Ports:
//     clk     in  : rising-edge clock
//     rst     in  : asynchronous active-low reset, counter takes RESET_VAL
//     load    in  : load loadVal on this edge (takes priority over counting)
//     loadVal in 7: phase length in cycles
//     last    out : count is 1, i.e. the current cycle is the last of the phase
//   The counter stops at zero so an untimed phase simply never asserts last.
import traffic_pkg::*;

module phase_timer #(
    parameter timer_t RESET_VAL = 7'd1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  timer_t loadVal,
    output logic   last
);

    timer_t cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= RESET_VAL;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != 7'd0) begin
            cnt <= cnt - 7'd1;
        end
    end

    assign last = (cnt == 7'd1);

endmodule

// File: rtl/light_phase_sequencer.sv
// light_phase_sequencer
//   Steps the DayTime lane selection through green, yellow and all-red
//   clearance, inserts pedestrian walk phases and preempts on emergency.
//   Priority: emergency, then pedestrian, then normal.
//   Ports:
//     clk        in   : rising-edge clock
//     rst        in   : asynchronous active-low reset
//     lane_sel   in 8 : DayTime lane selection, WWSSEENN (bit0 = N1)
//     load_timer in 7 : DayTime green length in cycles
//     ped_req    in   : pedestrian request (one pulse is enough)
//     emg_req    in   : emergency request, level
//     green      out 8: green lamps, lane_sel bit order
//     yellow     out 8: yellow lamps, lane_sel bit order
//     walk       out  : pedestrian walk lamp
//     is_zero    out  : high during the SELECT cycle while DayTime is sampled
//     phase      out 3: current phase encoding
//   Every lamp output is a pure decode of the state and lanesQ flops, so the
//   asynchronous reset drops the lamps without waiting for a clock edge.
import traffic_pkg::*;

module light_phase_sequencer #(
    parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
    parameter int PED_CYCLES     = DEF_PED_CYCLES,
    parameter int MIN_GREEN      = DEF_MIN_GREEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lane_sel,
    input  logic [6:0] load_timer,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic       walk,
    output logic       is_zero,
    output logic [2:0] phase
);

    localparam timer_t YELLOW_LEN  = timer_t'(YELLOW_CYCLES);
    localparam timer_t ALL_RED_LEN = timer_t'(ALL_RED_CYCLES);
    localparam timer_t PED_LEN     = timer_t'(PED_CYCLES);
    localparam timer_t MIN_GREEN_T = timer_t'(MIN_GREEN);

    phase_e     state;
    phase_e     nextState;
    logic       last;
    logic       loadEn;
    timer_t     loadVal;
    logic       latchLanes;
    logic       enterPed;
    logic [7:0] lanesQ;
    logic       pedPending;

    // Reset leaves the sequencer in ALL_RED with a full clearance count, so
    // the first SELECT follows ALL_RED_CYCLES edges after release.
    phase_timer #(
        .RESET_VAL (ALL_RED_LEN)
    ) uTimer (
        .clk     (clk),
        .rst     (rst),
        .load    (loadEn),
        .loadVal (loadVal),
        .last    (last)
    );

    always_comb begin
        nextState  = state;
        loadEn     = 1'b0;
        loadVal    = ALL_RED_LEN;
        latchLanes = 1'b0;
        enterPed   = 1'b0;
        case (state)
            PH_SELECT: begin
                // SELECT is always a single cycle; an empty selection or an
                // emergency falls back to clearance without latching lanes.
                loadEn = 1'b1;
                if (emg_req || (lane_sel == 8'h00)) begin
                    nextState = PH_ALL_RED;
                    loadVal   = ALL_RED_LEN;
                end else begin
                    nextState  = PH_GREEN;
                    loadVal    = clampGreen(load_timer, MIN_GREEN_T);
                    latchLanes = 1'b1;
                end
            end
            PH_GREEN: begin
                if (emg_req || last) begin
                    nextState = PH_YELLOW;
                    loadEn    = 1'b1;
                    loadVal   = YELLOW_LEN;
                end
            end
            PH_YELLOW: begin
                // Yellow always runs its full length, even under emergency.
                if (last) begin
                    nextState = PH_ALL_RED;
                    loadEn    = 1'b1;
                    loadVal   = ALL_RED_LEN;
                end
            end
            PH_ALL_RED: begin
                if (last) begin
                    loadEn = 1'b1;
                    if (emg_req) begin
                        nextState = PH_EMG;
                        loadVal   = 7'd1;
                    end else if (pedPending) begin
                        nextState = PH_PED;
                        loadVal   = PED_LEN;
                        enterPed  = 1'b1;
                    end else begin
                        nextState = PH_SELECT;
                        loadVal   = 7'd1;
                    end
                end
            end
            PH_PED: begin
                if (emg_req) begin
                    nextState = PH_ALL_RED;
                    loadEn    = 1'b1;
                    loadVal   = ALL_RED_LEN;
                end else if (last) begin
                    nextState = PH_SELECT;
                    loadEn    = 1'b1;
                    loadVal   = 7'd1;
                end
            end
            PH_EMG: begin
                // Held purely by the request level; the counter is ignored.
                if (!emg_req) begin
                    nextState = PH_ALL_RED;
                    loadEn    = 1'b1;
                    loadVal   = ALL_RED_LEN;
                end
            end
            default: begin
                nextState = PH_ALL_RED;
                loadEn    = 1'b1;
                loadVal   = ALL_RED_LEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PH_ALL_RED;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanesQ <= 8'h00;
        end else if (latchLanes) begin
            lanesQ <= lane_sel;
        end
    end

    // A request arriving on the PED-entry edge must survive the clear, so the
    // set term is tested first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pedPending <= 1'b0;
        end else if (ped_req) begin
            pedPending <= 1'b1;
        end else if (enterPed) begin
            pedPending <= 1'b0;
        end
    end

    assign green   = (state == PH_GREEN)  ? lanesQ : 8'h00;
    assign yellow  = (state == PH_YELLOW) ? lanesQ : 8'h00;
    assign walk    = (state == PH_PED);
    assign is_zero = (state == PH_SELECT);
    assign phase   = state;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// tb_light_phase_sequencer
//   Directed bench for light_phase_sequencer with default parameters.
//   A table of per-edge {inputs, expected outputs} records covers the normal
//   cycle, green clamping, empty selection and a pedestrian walk; hand-written
//   sequences cover emergency preemption, emergency/pedestrian priority,
//   walk abort and asynchronous reset in the middle of yellow.
module tb_light_phase_sequencer;

    typedef struct {
        logic [7:0] lane;
        logic [6:0] load;
        logic       ped;
        logic       emg;
        logic [7:0] g;
        logic [7:0] y;
        logic       w;
        logic       iz;
        logic [2:0] ph;
    } vec_t;

    localparam logic [7:0] L = 8'h03;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] laneSel;
    logic [6:0] loadTimer;
    logic       pedReq;
    logic       emgReq;
    logic [7:0] green;
    logic [7:0] yellow;
    logic       walk;
    logic       isZero;
    logic [2:0] phase;

    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    light_phase_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .lane_sel   (laneSel),
        .load_timer (loadTimer),
        .ped_req    (pedReq),
        .emg_req    (emgReq),
        .green      (green),
        .yellow     (yellow),
        .walk       (walk),
        .is_zero    (isZero),
        .phase      (phase)
    );

    task automatic checkOut(input string name, input logic [7:0] g, input logic [7:0] y,
                            input logic w, input logic iz, input logic [2:0] ph);
        logic [20:0] act;
        logic [20:0] exp;
        act = {green, yellow, walk, isZero, phase};
        exp = {g, y, w, iz, ph};
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got green=%h yellow=%h walk=%b is_zero=%b phase=%0d, want green=%h yellow=%h walk=%b is_zero=%b phase=%0d",
                     name, green, yellow, walk, isZero, phase, g, y, w, iz, ph);
        end
    endtask

    // Drive the inputs sampled by the next edge, then check just after it.
    task automatic applyVec(input vec_t v, input string name);
        laneSel   = v.lane;
        loadTimer = v.load;
        pedReq    = v.ped;
        emgReq    = v.emg;
        @(posedge clk);
        #1;
        checkOut(name, v.g, v.y, v.w, v.iz, v.ph);
    endtask

    task automatic addN(input int n, input logic [7:0] l, input logic [6:0] ld,
                        input logic p, input logic e, input logic [7:0] g, input logic [7:0] y,
                        input logic w, input logic iz, input logic [2:0] ph);
        vec_t v;
        v.lane = l; v.load = ld; v.ped = p; v.emg = e;
        v.g = g; v.y = y; v.w = w; v.iz = iz; v.ph = ph;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic step(input string name, input logic [7:0] l, input logic [6:0] ld,
                        input logic p, input logic e, input logic [7:0] g, input logic [7:0] y,
                        input logic w, input logic iz, input logic [2:0] ph);
        vec_t v;
        v.lane = l; v.load = ld; v.ped = p; v.emg = e;
        v.g = g; v.y = y; v.w = w; v.iz = iz; v.ph = ph;
        applyVec(v, name);
    endtask

    initial begin
        rst       = 1'b0;
        laneSel   = L;
        loadTimer = 7'd5;
        pedReq    = 1'b0;
        emgReq    = 1'b0;

        // Edges counted from reset release.
        // 1..13: lane 03, green 5 -> SELECT at 2 and 13 (period 11)
        addN(1, L, 5, 0, 0, 0, 0, 0, 0, 4);
        addN(1, L, 5, 0, 0, 0, 0, 0, 1, 1);
        addN(5, L, 5, 0, 0, L, 0, 0, 0, 2);
        addN(3, L, 5, 0, 0, 0, L, 0, 0, 3);
        addN(2, L, 5, 0, 0, 0, 0, 0, 0, 4);
        addN(1, L, 5, 0, 0, 0, 0, 0, 1, 1);
        // 14..21: load 0 clamps to 2 green cycles
        addN(2, L, 0, 0, 0, L, 0, 0, 0, 2);
        addN(3, L, 0, 0, 0, 0, L, 0, 0, 3);
        addN(2, L, 0, 0, 0, 0, 0, 0, 0, 4);
        addN(1, L, 0, 0, 0, 0, 0, 0, 1, 1);
        // 22..29: load 1 clamps to 2 green cycles
        addN(2, L, 1, 0, 0, L, 0, 0, 0, 2);
        addN(3, L, 1, 0, 0, 0, L, 0, 0, 3);
        addN(2, L, 1, 0, 0, 0, 0, 0, 0, 4);
        addN(1, L, 1, 0, 0, 0, 0, 0, 1, 1);
        // 30..32: empty selection retries through 2 cycles of ALL_RED
        addN(2, 8'h00, 5, 0, 0, 0, 0, 0, 0, 4);
        addN(1, 8'h00, 5, 0, 0, 0, 0, 0, 1, 1);
        // 33..64: ped pulse on the 2nd green cycle -> one 10-cycle walk
        addN(1, L, 5, 0, 0, L, 0, 0, 0, 2);
        addN(1, L, 5, 1, 0, L, 0, 0, 0, 2);
        addN(3, L, 5, 0, 0, L, 0, 0, 0, 2);
        addN(3, L, 5, 0, 0, 0, L, 0, 0, 3);
        addN(2, L, 5, 0, 0, 0, 0, 0, 0, 4);
        addN(10, L, 5, 0, 0, 0, 0, 1, 0, 5);
        addN(1, L, 5, 0, 0, 0, 0, 0, 1, 1);
        addN(5, L, 5, 0, 0, L, 0, 0, 0, 2);
        addN(3, L, 5, 0, 0, 0, L, 0, 0, 3);
        addN(2, L, 5, 0, 0, 0, 0, 0, 0, 4);
        addN(1, L, 5, 0, 0, 0, 0, 0, 1, 1);

        @(posedge clk);
        #1;
        checkOut("resetState", 8'h00, 8'h00, 1'b0, 1'b0, 3'd4);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], $sformatf("table%0d", i + 1));

        // Emergency rising on the 3rd green cycle of a 20-cycle green
        for (int i = 0; i < 3; i++) step("emgGreen", L, 20, 0, 0, L, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) step("emgYellow", L, 20, 0, 1, 0, L, 0, 0, 3);
        for (int i = 0; i < 2; i++) step("emgClear", L, 20, 0, 1, 0, 0, 0, 0, 4);
        for (int i = 0; i < 5; i++) step("emgHold", L, 20, 0, 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 2; i++) step("emgRelease", L, 20, 0, 0, 0, 0, 0, 0, 4);
        step("emgSelect", L, 20, 0, 0, 0, 0, 0, 1, 1);

        // Pending walk plus emergency: EMG wins, walk follows the release
        step("bothGreen", L, 2, 1, 0, L, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) step("bothYellow", L, 2, 0, 1, 0, L, 0, 0, 3);
        for (int i = 0; i < 2; i++) step("bothClear", L, 2, 0, 1, 0, 0, 0, 0, 4);
        step("bothEmg", L, 2, 0, 1, 0, 0, 0, 0, 6);
        for (int i = 0; i < 2; i++) step("bothRelease", L, 2, 0, 0, 0, 0, 0, 0, 4);
        step("bothWalk", L, 2, 0, 0, 0, 0, 1, 0, 5);
        // Emergency aborts the walk; the walk request was consumed on entry
        step("walkAbort", L, 2, 0, 1, 0, 0, 0, 0, 4);
        step("abortClear", L, 2, 0, 0, 0, 0, 0, 0, 4);
        step("abortSelect", L, 2, 0, 0, 0, 0, 0, 1, 1);

        // Asynchronous reset mid-yellow with a walk pending
        for (int i = 0; i < 2; i++) step("rstGreen", L, 2, 0, 0, L, 0, 0, 0, 2);
        step("rstYellowPed", L, 2, 1, 0, 0, L, 0, 0, 3);
        step("rstYellow", L, 2, 0, 0, 0, L, 0, 0, 3);
        #2;
        rst = 1'b0;
        #1;
        checkOut("rstAsync", 8'h00, 8'h00, 1'b0, 1'b0, 3'd4);
        #2;
        rst = 1'b1;
        step("rstClear", L, 2, 0, 0, 0, 0, 0, 0, 4);
        step("rstSelect", L, 2, 0, 0, 0, 0, 0, 1, 1);
        step("rstGreenAgain", L, 2, 0, 0, L, 0, 0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
